// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and helpers for the memory-game pattern engine.
package seq_pattern_gen_pkg;

  // Game controller states.
  typedef enum logic [2:0] {
    StIdle,
    StAppend,
    StShowOn,
    StShowOff,
    StGuess
  } state_e;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
  localparam logic [15:0] LfsrMask = 16'hB400;

  // Widest LED bus the one-hot helper can produce; callers cast down to their width.
  localparam int unsigned MaxWidth = 256;

  // One-hot decode of a button/LED index.
  function automatic logic [MaxWidth-1:0] onehot(input int unsigned idx);
    logic [MaxWidth-1:0] one;
    one = {{(MaxWidth - 1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; never cleared except by rst_n.
module lfsr16
  import seq_pattern_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  // Shift right, folding the feedback mask in when the outgoing bit is set.
  always_comb begin
    value_d = value_q >> 1;
    if (value_q[0]) begin
      value_d = value_d ^ LfsrMask;
    end
  end

  // State register; advances on every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/seq_pattern_gen.sv
// Sequence generator / checker for the memory game: grows a random one-hot
// pattern sequence, plays it back on tick-timed intervals and checks guesses.
module seq_pattern_gen
  import seq_pattern_gen_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ON_TICKS  = 4,
  parameter int unsigned OFF_TICKS = 2,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick,
  input  logic                         start,
  input  logic                         guess_valid,
  input  logic [$clog2(WIDTH)-1:0]     guess_idx,
  output logic [WIDTH-1:0]             con,
  output logic                         busy,
  output logic                         await_guess,
  output logic                         result_valid,
  output logic                         result_win,
  output logic [$clog2(DEPTH+1)-1:0]   length
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  // Address width of the sequence memory; idx/length carry one extra bit.
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // ---------------------------------------------------------------------------
  // Random source
  // ---------------------------------------------------------------------------
  logic [15:0]   lfsr;
  logic [IW-1:0] new_step;
  logic          unused_lfsr_hi;

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .value (lfsr)
  );

  assign new_step       = lfsr[IW-1:0];
  assign unused_lfsr_hi = ^lfsr[15:IW];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [LW-1:0] length_q, length_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic [7:0]    tcnt_inc;
  logic [IW-1:0] mem_q [DEPTH];
  logic          mem_we;
  logic [IW-1:0] mem_rd;
  logic          last_step;

  logic [WIDTH-1:0] con_q, con_d;
  logic             busy_q, busy_d;
  logic             await_q, await_d;
  logic             res_valid_q, res_valid_d;
  logic             res_win_q, res_win_d;
  logic [IW-1:0]    show_sel;

  assign mem_rd    = mem_q[idx_q[AW-1:0]];
  assign last_step = (idx_q == length_q - LW'(1));
  assign tcnt_inc  = tcnt_q + 8'd1;

  // Next-state logic; start overrides everything, including a same-cycle guess.
  always_comb begin
    state_d     = state_q;
    length_d    = length_q;
    idx_d       = idx_q;
    tcnt_d      = tcnt_q;
    mem_we      = 1'b0;
    res_valid_d = 1'b0;
    res_win_d   = 1'b0;

    if (start) begin
      length_d = '0;
      idx_d    = '0;
      tcnt_d   = '0;
      state_d  = StAppend;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StIdle;
        end

        StAppend: begin
          mem_we   = 1'b1;
          length_d = length_q + LW'(1);
          idx_d    = '0;
          tcnt_d   = '0;
          state_d  = StShowOn;
        end

        StShowOn: begin
          if (tick) begin
            if (tcnt_inc == 8'(ON_TICKS)) begin
              tcnt_d  = '0;
              state_d = StShowOff;
            end else begin
              tcnt_d = tcnt_inc;
            end
          end
        end

        StShowOff: begin
          if (tick) begin
            if (tcnt_inc == 8'(OFF_TICKS)) begin
              tcnt_d = '0;
              if (last_step) begin
                idx_d   = '0;
                state_d = StGuess;
              end else begin
                idx_d   = idx_q + LW'(1);
                state_d = StShowOn;
              end
            end else begin
              tcnt_d = tcnt_inc;
            end
          end
        end

        StGuess: begin
          if (guess_valid) begin
            if (guess_idx != mem_rd) begin
              res_valid_d = 1'b1;
              res_win_d   = 1'b0;
              state_d     = StIdle;
            end else if (!last_step) begin
              idx_d = idx_q + LW'(1);
            end else if (length_q < LW'(DEPTH)) begin
              state_d = StAppend;
            end else begin
              res_valid_d = 1'b1;
              res_win_d   = 1'b1;
              state_d     = StIdle;
            end
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Output look-ahead so con is lit in the very first SHOW_ON cycle. When the
  // step being shown is the one written this cycle, bypass the memory.
  always_comb begin
    show_sel = mem_q[idx_d[AW-1:0]];
    if (mem_we && (idx_d == length_q)) begin
      show_sel = new_step;
    end
    con_d   = (state_d == StShowOn) ? WIDTH'(onehot(32'(show_sel))) : '0;
    busy_d  = (state_d == StAppend) || (state_d == StShowOn) || (state_d == StShowOff);
    await_d = (state_d == StGuess);
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      length_q <= '0;
      idx_q    <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      length_q <= length_d;
      idx_q    <= idx_d;
      tcnt_q   <= tcnt_d;
    end
  end

  // Sequence memory: one entry appended per round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[length_q[AW-1:0]] <= new_step;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      con_q       <= '0;
      busy_q      <= 1'b0;
      await_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_win_q   <= 1'b0;
    end else begin
      con_q       <= con_d;
      busy_q      <= busy_d;
      await_q     <= await_d;
      res_valid_q <= res_valid_d;
      res_win_q   <= res_win_d;
    end
  end

  assign con          = con_q;
  assign busy         = busy_q;
  assign await_guess  = await_q;
  assign result_valid = res_valid_q;
  assign result_win   = res_win_q;
  assign length       = length_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: WIDTH=4, DEPTH=3, ON_TICKS=2, OFF_TICKS=1.
module tb_seq_pattern_gen;

  localparam int unsigned W   = 4;
  localparam int unsigned D   = 3;
  localparam int unsigned ON  = 2;
  localparam int unsigned OFF = 1;

  localparam int EvShow   = 1;
  localparam int EvOn     = 2;
  localparam int EvOff    = 3;
  localparam int EvAwait  = 4;
  localparam int EvResult = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       start;
  logic       guess_valid;
  logic [1:0] guess_idx;
  logic [3:0] con;
  logic       busy;
  logic       await_guess;
  logic       result_valid;
  logic       result_win;
  logic [1:0] length;

  seq_pattern_gen #(
    .WIDTH     (W),
    .DEPTH     (D),
    .ON_TICKS  (ON),
    .OFF_TICKS (OFF),
    .SEED      (16'hACE1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .start        (start),
    .guess_valid  (guess_valid),
    .guess_idx    (guess_idx),
    .con          (con),
    .busy         (busy),
    .await_guess  (await_guess),
    .result_valid (result_valid),
    .result_win   (result_win),
    .length       (length)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         mon_en   = 1'b0;
  logic [15:0] lfsr_m;
  logic [1:0] mem_m [D];
  int         tcyc = 0;

  // Reference LFSR from the polynomial, same reset as the DUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
  end

  // Free-running tick: one cycle in four.
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tcyc = tcyc + 1;
      tick = (tcyc % 4 == 0);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      check($sformatf("unexpected event kind %0d", kind), kind * 256 + val, -1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event kind %0d (kind*256+val)", e.kind), kind * 256 + val,
            e.kind * 256 + e.val);
    end
  endtask

  // Monitor: turns DUT output activity into events and checks them in order.
  logic [3:0] prev_con   = '0;
  bit         prev_await = 1'b0;
  bit         in_off     = 1'b0;
  int         on_cnt     = 0;
  int         off_cnt    = 0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (con != prev_con) begin
          if (prev_con != 0) begin
            observe(EvOn, on_cnt);
            in_off  = 1'b1;
            off_cnt = 0;
          end
          if (con != 0) begin
            if (in_off) begin
              observe(EvOff, off_cnt);
              in_off = 1'b0;
            end
            observe(EvShow, int'(con));
            on_cnt = 0;
          end
        end
        if (await_guess && !prev_await) begin
          if (in_off) begin
            observe(EvOff, off_cnt);
            in_off = 1'b0;
          end
          observe(EvAwait, int'(length));
        end
        if (result_valid) observe(EvResult, int'(result_win));
        if (tick) begin
          if (con != 0) on_cnt++;
          else if (in_off) off_cnt++;
        end
      end else begin
        in_off = 1'b0;
      end
      prev_con   = con;
      prev_await = await_guess;
    end
  end

  task automatic wait_await();
    int n;
    n = 0;
    while (!await_guess && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("await_guess within budget", int'(await_guess), 1);
  endtask

  // Pulse start; capture the appended step during the APPEND cycle.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mem_m[0] = lfsr_m[1:0];
  endtask

  // Expect playback of len steps, then guess them; bad >= 0 mis-guesses that step.
  task automatic play_round(input int len, input int bad);
    logic [3:0] oh;
    for (int i = 0; i < len; i++) begin
      oh = 4'b0001 << mem_m[i];
      push(EvShow, int'(oh));
      push(EvOn, ON);
      push(EvOff, OFF);
    end
    push(EvAwait, len);
    wait_await();
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      guess_idx   = (i == bad) ? (mem_m[i] ^ 2'b01) : mem_m[i];
      guess_valid = 1'b1;
      if (i == bad) push(EvResult, 0);
      else if (i == len - 1 && len == int'(D)) push(EvResult, 1);
      @(negedge clk);
      guess_valid = 1'b0;
      if (i == bad) break;
      if (i == len - 1 && len < int'(D)) mem_m[len] = lfsr_m[1:0];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] oh;
    int         n;

    rst_n       = 1'b0;
    start       = 1'b0;
    guess_valid = 1'b0;
    guess_idx   = '0;

    // Reset held with tick running.
    repeat (6) @(negedge clk);
    check("reset con", int'(con), 0);
    check("reset busy", int'(busy), 0);
    check("reset await_guess", int'(await_guess), 0);
    check("reset result_valid", int'(result_valid), 0);
    check("reset length", int'(length), 0);
    check("reset lfsr", int'(dut.u_lfsr.value), 16'hACE1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle con", int'(con), 0);

    // Game 1: three correct rounds, win at DEPTH.
    mon_en = 1'b1;
    do_start();
    play_round(1, -1);
    play_round(2, -1);
    play_round(3, -1);
    repeat (4) @(negedge clk);
    check("game1 scoreboard drained", exp_q.size(), 0);
    check("game1 busy after win", int'(busy), 0);
    check("game1 await after win", int'(await_guess), 0);
    check("game1 length held", int'(length), 3);

    // Game 2: wrong first guess in round 2.
    do_start();
    play_round(1, -1);
    play_round(2, 0);
    repeat (3) @(negedge clk);
    check("game2 scoreboard drained", exp_q.size(), 0);
    check("game2 con after loss", int'(con), 0);
    check("game2 busy after loss", int'(busy), 0);
    check("game2 await after loss", int'(await_guess), 0);
    check("game2 length held", int'(length), 2);
    mon_en = 1'b0;

    // Game 3: guess during SHOW_ON is ignored, start mid-SHOW_ON restarts.
    do_start();
    a = mem_m[0];
    n = 0;
    while (con == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    oh = 4'b0001 << a;
    check("game3 first step lit", int'(con), int'(oh));
    guess_valid = 1'b1;
    guess_idx   = a ^ 2'b01;
    @(negedge clk);
    guess_valid = 1'b0;
    check("guess in SHOW_ON: no result", int'(result_valid), 0);
    check("guess in SHOW_ON: still lit", int'(con), int'(oh));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b = lfsr_m[1:0];
    mem_m[0] = b;
    check("restart length cleared", int'(length), 0);
    check("restart con dark in APPEND", int'(con), 0);
    check("restart busy", int'(busy), 1);
    @(negedge clk);
    oh = 4'b0001 << b;
    check("restart length two cycles later", int'(length), 1);
    check("restart new step lit", int'(con), int'(oh));
    wait_await();
    check("game3 length at guess", int'(length), 1);

    // Asynchronous reset while in GUESS.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset await_guess", int'(await_guess), 0);
    check("async reset length", int'(length), 0);
    check("async reset busy", int'(busy), 0);
    check("async reset con", int'(con), 0);
    check("async reset lfsr", int'(dut.u_lfsr.value), 16'hACE1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post reset idle busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
